// File: rtl/mesi_snoop_bus_ctrl_if.sv
// Snooping-bus interface between the MESI bus controller and the per-core
// L1 caches plus the single memory port.
//   master modport : the bus controller (mesi_snoop_bus_ctrl)
//   slave modport  : caches and memory
//
// Handshakes. req_valid[i] must be held with stable req_* until the one-cycle
// req_ready[i] pulse. snp_valid stays high until every non-requesting core has
// pulsed snp_ack at least once. mem_valid with its attributes stays stable
// until a cycle in which mem_ready is high; read data follows later on
// mem_rvalid. rsp_valid is a one-cycle pulse with no back-pressure.
interface mesi_snoop_bus_ctrl_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 32,
    parameter int CID_W     = 2
);
    logic [NUM_CORES-1:0]        req_valid;
    logic [2*NUM_CORES-1:0]      req_op;
    logic [ADDR_W*NUM_CORES-1:0] req_addr;
    logic [DATA_W*NUM_CORES-1:0] req_wdata;
    logic [NUM_CORES-1:0]        req_ready;

    logic                        snp_valid;
    logic [1:0]                  snp_op;
    logic [ADDR_W-1:0]           snp_addr;
    logic [CID_W-1:0]            snp_src;
    logic [NUM_CORES-1:0]        snp_ack;
    logic [NUM_CORES-1:0]        snp_shared;
    logic [NUM_CORES-1:0]        snp_dirty;
    logic [DATA_W*NUM_CORES-1:0] snp_data;

    logic                        mem_valid;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_ready;
    logic                        mem_rvalid;
    logic [DATA_W-1:0]           mem_rdata;

    logic [NUM_CORES-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic [1:0]                  rsp_state;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready,
        output snp_valid, snp_op, snp_addr, snp_src,
        input  snp_ack, snp_shared, snp_dirty, snp_data,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_data, rsp_state
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready,
        input  snp_valid, snp_op, snp_addr, snp_src,
        output snp_ack, snp_shared, snp_dirty, snp_data,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_data, rsp_state
    );
endinterface

// File: rtl/mesi_snoop_bus_ctrl.sv
// MESI snooping-bus controller for NUM_CORES L1 caches. Round-robin
// arbitration, one snoop broadcast per transaction, snoop-reply merge,
// single memory port, and a one-cycle response carrying the granted state.
// Optional build macro MESI_C2C_XFER_EN: dirty BusRd/BusRdX take the fill
// data straight from the owning cache instead of re-reading memory.
// All outputs are decoded from registered state, so the asynchronous reset
// forces every output low immediately.
module mesi_snoop_bus_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 32,
    parameter int CID_W     = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    mesi_snoop_bus_ctrl_if.master bus,
    output logic [2:0]            dbg_state
);
    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_RDX  = 2'b01;
    localparam logic [1:0] OP_UPGR = 2'b10;
    localparam logic [1:0] OP_WB   = 2'b11;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_SNOOP = 3'd2,
        S_WB    = 3'd3,
        S_MEMRD = 3'd4,
        S_RESP  = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [CID_W-1:0]     rr_q, rr_d;
    logic [CID_W-1:0]     id_q, id_d;
    logic [CID_W-1:0]     owner_q, owner_d;
    logic [1:0]           op_q, op_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    own_data_q, own_data_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic                 shared_q, shared_d;
    logic                 dirty_q, dirty_d;
    logic                 rd_issued_q, rd_issued_d;

    logic                 arb_found;
    logic [CID_W-1:0]     arb_win;
    logic [NUM_CORES-1:0] id_onehot;
    logic [NUM_CORES-1:0] new_ack;
    logic                 nd_found;
    logic [CID_W-1:0]     nd_idx;
    logic [DATA_W-1:0]    nd_data;

    assign dbg_state = state_q;

    // Round-robin search: first requester at or after rr_q, wrapping.
    always_comb begin
        logic [CID_W:0] cand;
        cand      = '0;
        arb_found = 1'b0;
        arb_win   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = {1'b0, rr_q} + (CID_W+1)'(k);
            if (cand >= (CID_W+1)'(NUM_CORES)) begin
                cand = cand - (CID_W+1)'(NUM_CORES);
            end
            if (!arb_found && bus.req_valid[cand[CID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = cand[CID_W-1:0];
            end
        end
    end

    // Snoop-reply filtering: first-time acks from non-requesters, and the
    // lowest-index dirty core among those arriving this cycle.
    always_comb begin
        id_onehot       = '0;
        id_onehot[id_q] = 1'b1;
        new_ack         = bus.snp_ack & ~ack_q & ~id_onehot;
        nd_found        = 1'b0;
        nd_idx          = '0;
        nd_data         = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (new_ack[j] && bus.snp_dirty[j]) begin
                nd_found = 1'b1;
                nd_idx   = CID_W'(j);
                nd_data  = bus.snp_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM: next state, latched transaction fields and bus outputs.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        owner_d     = owner_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        own_data_d  = own_data_q;
        data_d      = data_q;
        ack_d       = ack_q;
        shared_d    = shared_q;
        dirty_d     = dirty_q;
        rd_issued_d = rd_issued_q;

        bus.req_ready = '0;
        bus.snp_valid = 1'b0;
        bus.snp_op    = '0;
        bus.snp_addr  = '0;
        bus.snp_src   = '0;
        bus.mem_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.rsp_state = ST_I;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    id_d        = arb_win;
                    op_d        = bus.req_op[arb_win*2 +: 2];
                    addr_d      = bus.req_addr[arb_win*ADDR_W +: ADDR_W];
                    wdata_d     = bus.req_wdata[arb_win*DATA_W +: DATA_W];
                    rr_d        = (arb_win == CID_W'(NUM_CORES - 1)) ? '0 : arb_win + 1'b1;
                    owner_d     = '0;
                    own_data_d  = '0;
                    data_d      = '0;
                    ack_d       = '0;
                    shared_d    = 1'b0;
                    dirty_d     = 1'b0;
                    rd_issued_d = 1'b0;
                    state_d     = S_GRANT;
                end
            end

            S_GRANT: begin
                bus.req_ready = id_onehot;
                state_d       = (op_q == OP_WB) ? S_WB : S_SNOOP;
            end

            S_SNOOP: begin
                bus.snp_valid = 1'b1;
                bus.snp_op    = op_q;
                bus.snp_addr  = addr_q;
                bus.snp_src   = id_q;
                ack_d         = ack_q | new_ack;
                shared_d      = shared_q | (|(bus.snp_shared & new_ack));
                if (nd_found && (!dirty_q || (nd_idx < owner_q))) begin
                    dirty_d    = 1'b1;
                    owner_d    = nd_idx;
                    own_data_d = nd_data;
                end
                if (&(ack_d | id_onehot)) begin
                    if (dirty_d) begin
`ifdef MESI_C2C_XFER_EN
                        data_d  = own_data_d;
                        state_d = (op_q == OP_RD) ? S_WB : S_RESP;
`else
                        state_d = S_WB;
`endif
                    end else if (op_q == OP_UPGR) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_MEMRD;
                    end
                end
            end

            S_WB: begin
                bus.mem_valid = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = dirty_q ? own_data_q : wdata_q;
                if (bus.mem_ready) begin
`ifdef MESI_C2C_XFER_EN
                    state_d = S_RESP;
`else
                    state_d = (op_q == OP_WB) ? S_RESP : S_MEMRD;
`endif
                end
            end

            S_MEMRD: begin
                if (!rd_issued_q) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_addr  = addr_q;
                    if (bus.mem_ready) begin
                        rd_issued_d = 1'b1;
                    end
                end else if (bus.mem_rvalid) begin
                    data_d  = bus.mem_rdata;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                bus.rsp_valid = id_onehot;
                bus.rsp_data  = data_q;
                case (op_q)
                    OP_RD:   bus.rsp_state = shared_q ? ST_S : ST_E;
                    OP_RDX:  bus.rsp_state = ST_M;
                    OP_UPGR: bus.rsp_state = ST_M;
                    default: bus.rsp_state = ST_I;
                endcase
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            owner_q     <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            own_data_q  <= '0;
            data_q      <= '0;
            ack_q       <= '0;
            shared_q    <= 1'b0;
            dirty_q     <= 1'b0;
            rd_issued_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            own_data_q  <= own_data_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            shared_q    <= shared_d;
            dirty_q     <= dirty_d;
            rd_issued_q <= rd_issued_d;
        end
    end
endmodule

// File: tb/tb_mesi_snoop_bus_ctrl.sv
// Directed self-checking bench for mesi_snoop_bus_ctrl. A background
// responder plays the snooping caches and a small memory; each test task
// issues requests and compares observations with hand-derived values.
// Build with MESI_C2C_XFER_EN defined to check the cache-to-cache variant.
module tb_mesi_snoop_bus_ctrl;
    localparam int NC = 4;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int CW = 2;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_RDX  = 2'b01;
    localparam logic [1:0] OP_UPGR = 2'b10;
    localparam logic [1:0] OP_WB   = 2'b11;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    mesi_snoop_bus_ctrl_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .CID_W(CW)) bus ();

    mesi_snoop_bus_ctrl #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .CID_W(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- responder configuration / observations ----------------
    logic [NC-1:0] cfg_shared = '0;
    logic [NC-1:0] cfg_dirty  = '0;
    logic [DW-1:0] cfg_own_data [NC];
    bit            cfg_stagger = 1'b0;
    bit            cfg_no_ack  = 1'b0;
    int            cfg_stall   = 0;

    int            snp_run = 0, snp_last_run = 0, snp_total = 0;
    logic [1:0]    snp_op_seen;
    logic [AW-1:0] snp_addr_seen;
    logic [CW-1:0] snp_src_seen;
    int            wr_cnt = 0, rd_cnt = 0, stall_seen = 0, stall_left = 0;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    bit            rd_pend = 1'b0;
    logic [DW-1:0] mem_m [logic [AW-1:0]];

    // Caches and memory: snoop replies and a one-cycle-latency memory.
    initial begin
        bus.snp_ack    = '0;
        bus.snp_shared = '0;
        bus.snp_dirty  = '0;
        bus.snp_data   = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        mem_m[20'h00100] = 32'hCAFE0001;
        mem_m[20'h00200] = 32'h0BAD0000;
        mem_m[20'h00700] = 32'h0BAD0007;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                bus.snp_ack    = '0;
                bus.mem_ready  = 1'b0;
                bus.mem_rvalid = 1'b0;
                rd_pend        = 1'b0;
                snp_run        = 0;
            end else begin
                if (bus.snp_valid) begin
                    snp_run++;
                    snp_total++;
                    snp_last_run  = snp_run;
                    snp_op_seen   = bus.snp_op;
                    snp_addr_seen = bus.snp_addr;
                    snp_src_seen  = bus.snp_src;
                    if (cfg_no_ack)                       bus.snp_ack = '0;
                    else if (cfg_stagger && snp_run == 1) bus.snp_ack = 4'b0101;
                    else                                  bus.snp_ack = '1;
                    bus.snp_shared = cfg_shared;
                    bus.snp_dirty  = cfg_dirty;
                    for (int i = 0; i < NC; i++) bus.snp_data[i*DW +: DW] = cfg_own_data[i];
                end else begin
                    snp_run        = 0;
                    bus.snp_ack    = '0;
                    bus.snp_shared = '0;
                    bus.snp_dirty  = '0;
                end
                bus.mem_rvalid = rd_pend;
                bus.mem_rdata  = (rd_pend && mem_m.exists(rd_addr)) ? mem_m[rd_addr] : '0;
                rd_pend        = 1'b0;
                if (bus.mem_valid) begin
                    if (stall_left > 0) begin
                        bus.mem_ready = 1'b0;
                        stall_left--;
                        stall_seen++;
                    end else begin
                        bus.mem_ready = 1'b1;
                        if (bus.mem_we) begin
                            wr_cnt++;
                            wr_addr = bus.mem_addr;
                            wr_data = bus.mem_wdata;
                            mem_m[bus.mem_addr] = bus.mem_wdata;
                        end else begin
                            rd_cnt++;
                            rd_pend = 1'b1;
                            rd_addr = bus.mem_addr;
                        end
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                    stall_left    = cfg_stall;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int            grant_log[$];
    int            multi_grant = 0;
    logic [NC-1:0] last_rsp_valid;
    logic [DW-1:0] last_rsp_data;
    logic [1:0]    last_rsp_state;

    task automatic issue(input int c, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bus.req_valid[c]            = 1'b1;
        bus.req_op[c*2 +: 2]        = op;
        bus.req_addr[c*AW +: AW]    = a;
        bus.req_wdata[c*DW +: DW]   = d;
    endtask

    // Step cycles until n_rsp responses or the budget runs out; drops each
    // request once it is granted.
    task automatic run_txns(input int n_rsp, input int budget, output int got);
        got = 0;
        for (int cyc = 0; cyc < budget && got < n_rsp; cyc++) begin
            @(posedge clk); #1;
            if ($countones(bus.req_ready) > 1) multi_grant++;
            for (int k = 0; k < NC; k++) begin
                if (bus.req_ready[k]) begin
                    bus.req_valid[k] = 1'b0;
                    grant_log.push_back(k);
                end
            end
            if (bus.rsp_valid != '0) begin
                got++;
                last_rsp_valid = bus.rsp_valid;
                last_rsp_data  = bus.rsp_data;
                last_rsp_state = bus.rsp_state;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int  got;
        bit  saw_snp = 1'b0;
        cfg_no_ack = 1'b1;
        issue(1, OP_RD, 20'h00500, '0);
        for (int cyc = 0; cyc < 10 && !saw_snp; cyc++) begin
            @(posedge clk); #1;
            if (bus.req_ready[1]) bus.req_valid[1] = 1'b0;
            if (bus.snp_valid) saw_snp = 1'b1;
        end
        n_checks++; if (saw_snp !== 1'b1) $display("FAIL rst_reach_snoop: got %0b expected 1", saw_snp); else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (dbg_state !== 3'd0) $display("FAIL rst_state: got %0d expected 0", dbg_state); else n_pass++;
        n_checks++; if (bus.snp_valid !== 1'b0) $display("FAIL rst_snp_valid: got %0b expected 0", bus.snp_valid); else n_pass++;
        n_checks++; if (bus.snp_addr !== '0) $display("FAIL rst_snp_addr: got %h expected 0", bus.snp_addr); else n_pass++;
        n_checks++; if (bus.req_ready !== '0) $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); else n_pass++;
        n_checks++; if (bus.mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %0b expected 0", bus.mem_valid); else n_pass++;
        n_checks++; if (bus.rsp_valid !== '0) $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); else n_pass++;
        cfg_no_ack = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        run_txns(1, 8, got);
        n_checks++; if (got !== 0) $display("FAIL rst_no_rsp: got %0d responses expected 0", got); else n_pass++;
        n_checks++; if (dbg_state !== 3'd0) $display("FAIL rst_idle_after: got %0d expected 0", dbg_state); else n_pass++;
    endtask

    task automatic test_clean_read();
        int got, wr0, rd0;
        cfg_shared = '0; cfg_dirty = '0; cfg_stagger = 1'b0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        issue(0, OP_RD, 20'h00100, '0);
        run_txns(1, 40, got);
        n_checks++; if (got !== 1) $display("FAIL clean_got_rsp: got %0d expected 1", got); else n_pass++;
        n_checks++; if (last_rsp_valid !== 4'b0001) $display("FAIL clean_rsp_valid: got %b expected 0001", last_rsp_valid); else n_pass++;
        n_checks++; if (last_rsp_data !== 32'hCAFE0001) $display("FAIL clean_rsp_data: got %h expected cafe0001", last_rsp_data); else n_pass++;
        n_checks++; if (last_rsp_state !== 2'b10) $display("FAIL clean_rsp_state: got %b expected 10", last_rsp_state); else n_pass++;
        n_checks++; if (rd_cnt - rd0 !== 1) $display("FAIL clean_mem_reads: got %0d expected 1", rd_cnt - rd0); else n_pass++;
        n_checks++; if (wr_cnt - wr0 !== 0) $display("FAIL clean_mem_writes: got %0d expected 0", wr_cnt - wr0); else n_pass++;
        n_checks++; if (snp_addr_seen !== 20'h00100) $display("FAIL clean_snp_addr: got %h expected 00100", snp_addr_seen); else n_pass++;
        n_checks++; if (snp_src_seen !== 2'd0) $display("FAIL clean_snp_src: got %0d expected 0", snp_src_seen); else n_pass++;
        n_checks++; if (snp_op_seen !== OP_RD) $display("FAIL clean_snp_op: got %b expected 00", snp_op_seen); else n_pass++;
    endtask

    task automatic test_dirty_read();
        int got, wr0, rd0, exp_rd;
        cfg_shared = 4'b0010; cfg_dirty = 4'b0010; cfg_stagger = 1'b1;
        cfg_own_data[1] = 32'hDEAD0002;
        cfg_own_data[3] = 32'hFFFF0003;
        wr0 = wr_cnt; rd0 = rd_cnt;
`ifdef MESI_C2C_XFER_EN
        exp_rd = 0;
`else
        exp_rd = 1;
`endif
        issue(2, OP_RD, 20'h00200, '0);
        run_txns(1, 40, got);
        n_checks++; if (got !== 1) $display("FAIL dirty_got_rsp: got %0d expected 1", got); else n_pass++;
        n_checks++; if (snp_last_run !== 2) $display("FAIL dirty_snoop_cycles: got %0d expected 2", snp_last_run); else n_pass++;
        n_checks++; if (snp_src_seen !== 2'd2) $display("FAIL dirty_snp_src: got %0d expected 2", snp_src_seen); else n_pass++;
        n_checks++; if (wr_cnt - wr0 !== 1) $display("FAIL dirty_mem_writes: got %0d expected 1", wr_cnt - wr0); else n_pass++;
        n_checks++; if (wr_addr !== 20'h00200) $display("FAIL dirty_wb_addr: got %h expected 00200", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 32'hDEAD0002) $display("FAIL dirty_wb_data: got %h expected dead0002", wr_data); else n_pass++;
        n_checks++; if (rd_cnt - rd0 !== exp_rd) $display("FAIL dirty_mem_reads: got %0d expected %0d", rd_cnt - rd0, exp_rd); else n_pass++;
        n_checks++; if (last_rsp_valid !== 4'b0100) $display("FAIL dirty_rsp_valid: got %b expected 0100", last_rsp_valid); else n_pass++;
        n_checks++; if (last_rsp_state !== 2'b01) $display("FAIL dirty_rsp_state: got %b expected 01", last_rsp_state); else n_pass++;
        n_checks++; if (last_rsp_data !== 32'hDEAD0002) $display("FAIL dirty_rsp_data: got %h expected dead0002", last_rsp_data); else n_pass++;
        cfg_stagger = 1'b0; cfg_dirty = '0; cfg_shared = '0;
    endtask

    task automatic test_upgrade();
        int got, wr0, rd0;
        cfg_shared = 4'b0001; cfg_dirty = '0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        issue(3, OP_UPGR, 20'h00300, '0);
        run_txns(1, 40, got);
        n_checks++; if (got !== 1) $display("FAIL upgr_got_rsp: got %0d expected 1", got); else n_pass++;
        n_checks++; if (last_rsp_valid !== 4'b1000) $display("FAIL upgr_rsp_valid: got %b expected 1000", last_rsp_valid); else n_pass++;
        n_checks++; if (last_rsp_state !== 2'b11) $display("FAIL upgr_rsp_state: got %b expected 11", last_rsp_state); else n_pass++;
        n_checks++; if ((wr_cnt - wr0) + (rd_cnt - rd0) !== 0) $display("FAIL upgr_mem_access: got %0d expected 0", (wr_cnt - wr0) + (rd_cnt - rd0)); else n_pass++;
        n_checks++; if (snp_op_seen !== OP_UPGR) $display("FAIL upgr_snp_op: got %b expected 10", snp_op_seen); else n_pass++;
        cfg_shared = '0;
    endtask

    task automatic test_back_to_back();
        int         got;
        logic [1:0] exp_q[$];
        logic [1:0] exp_id;
        int         act_id;
        cfg_shared = '0; cfg_dirty = '0;
        grant_log.delete();
        multi_grant = 0;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int c = 0; c < NC; c++) issue(c, OP_RD, 20'h00600 + AW'(c * 16), '0);
        run_txns(4, 120, got);
        n_checks++; if (got !== 4) $display("FAIL rr_got_rsp: got %0d expected 4", got); else n_pass++;
        n_checks++; if (multi_grant !== 0) $display("FAIL rr_single_grant: got %0d multi-grant cycles expected 0", multi_grant); else n_pass++;
        while (exp_q.size() > 0) begin
            exp_id = exp_q.pop_front();
            act_id = (grant_log.size() > 0) ? grant_log.pop_front() : -1;
            n_checks++; if (act_id !== int'(exp_id)) $display("FAIL rr_grant_order: got %0d expected %0d", act_id, exp_id); else n_pass++;
        end
        grant_log.delete();
        issue(1, OP_RD, 20'h00640, '0);
        run_txns(1, 40, got);
        act_id = (grant_log.size() > 0) ? grant_log[0] : -1;
        n_checks++; if (act_id !== 1) $display("FAIL rr_regrant: got %0d expected 1", act_id); else n_pass++;
    endtask

    task automatic test_rdx_dirty();
        int got, wr0, rd0, exp_wr, exp_rd;
        cfg_shared = 4'b0100; cfg_dirty = 4'b0100;
        cfg_own_data[2] = 32'hBEEF0007;
        wr0 = wr_cnt; rd0 = rd_cnt;
`ifdef MESI_C2C_XFER_EN
        exp_wr = 0; exp_rd = 0;
`else
        exp_wr = 1; exp_rd = 1;
`endif
        issue(0, OP_RDX, 20'h00700, '0);
        run_txns(1, 40, got);
        n_checks++; if (got !== 1) $display("FAIL rdx_got_rsp: got %0d expected 1", got); else n_pass++;
        n_checks++; if (last_rsp_state !== 2'b11) $display("FAIL rdx_rsp_state: got %b expected 11", last_rsp_state); else n_pass++;
        n_checks++; if (last_rsp_data !== 32'hBEEF0007) $display("FAIL rdx_rsp_data: got %h expected beef0007", last_rsp_data); else n_pass++;
        n_checks++; if (wr_cnt - wr0 !== exp_wr) $display("FAIL rdx_mem_writes: got %0d expected %0d", wr_cnt - wr0, exp_wr); else n_pass++;
        n_checks++; if (rd_cnt - rd0 !== exp_rd) $display("FAIL rdx_mem_reads: got %0d expected %0d", rd_cnt - rd0, exp_rd); else n_pass++;
        cfg_shared = '0; cfg_dirty = '0;
    endtask

    task automatic test_writeback();
        int got, wr0, rd0, snp0, st0;
        cfg_stall = 3;
        wr0 = wr_cnt; rd0 = rd_cnt; snp0 = snp_total; st0 = stall_seen;
        issue(2, OP_WB, 20'h00400, 32'h12345678);
        run_txns(1, 40, got);
        n_checks++; if (got !== 1) $display("FAIL wb_got_rsp: got %0d expected 1", got); else n_pass++;
        n_checks++; if (snp_total - snp0 !== 0) $display("FAIL wb_no_snoop: got %0d snoop cycles expected 0", snp_total - snp0); else n_pass++;
        n_checks++; if (stall_seen - st0 !== 3) $display("FAIL wb_stall_held: got %0d expected 3", stall_seen - st0); else n_pass++;
        n_checks++; if (wr_cnt - wr0 !== 1) $display("FAIL wb_mem_writes: got %0d expected 1", wr_cnt - wr0); else n_pass++;
        n_checks++; if (wr_addr !== 20'h00400) $display("FAIL wb_addr: got %h expected 00400", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 32'h12345678) $display("FAIL wb_data: got %h expected 12345678", wr_data); else n_pass++;
        n_checks++; if (rd_cnt - rd0 !== 0) $display("FAIL wb_mem_reads: got %0d expected 0", rd_cnt - rd0); else n_pass++;
        n_checks++; if (last_rsp_valid !== 4'b0100) $display("FAIL wb_rsp_valid: got %b expected 0100", last_rsp_valid); else n_pass++;
        n_checks++; if (last_rsp_state !== 2'b00) $display("FAIL wb_rsp_state: got %b expected 00", last_rsp_state); else n_pass++;
        cfg_stall = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NC; i++) cfg_own_data[i] = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        test_reset();
        test_clean_read();
        test_dirty_read();
        test_upgrade();
        test_back_to_back();
        test_rdx_dirty();
        test_writeback();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
